// File: rtl/regwr_arbiter_pkg.sv
// Shared defaults and helpers for the register-file write-port arbiter.
// Holds requester/width defaults and the one-hot register decode.
package regwr_arbiter_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Widest register address the shared decoder supports.
    localparam int MAX_ADDR_W = 8;
    localparam int MAX_NREG   = 2 ** MAX_ADDR_W;

    function automatic logic [MAX_NREG-1:0] addr_dec(
        input logic [MAX_ADDR_W-1:0] a
    );
        logic [MAX_NREG-1:0] dec;
        dec    = '0;
        dec[a] = 1'b1;
        return dec;
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regwr_arbiter_rr_pick.sv
// Rotating-base priority pick: first set request at or after ptr_i.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick
    import regwr_arbiter_pkg::*;
#(
    parameter int N  = NREQ_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int k;

    // Scan offsets high to low so the smallest offset from ptr_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        for (int j = N - 1; j >= 0; j--) begin
            k = int'(ptr_i) + j;
            if (k >= N) begin
                k = k - N;
            end
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ
// requesters; grant is combinational, the write issues one cycle later.
module regwr_arbiter
    import regwr_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREG   = 2 ** ADDR_W,
    parameter int IW     = idx_w(NREQ)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   hold,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREG-1:0]        wr_en,
    output logic [DATA_W-1:0]      wr_data,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [IW-1:0]          gnt_id,
    output logic                   wr_fire
);

    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     ptr_d;
    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              arb_ok;
    logic              hs;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   wr_en_d;
    logic [NREG-1:0]   wr_en_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [IW-1:0]     gnt_id_q;
    logic              wr_fire_q;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign arb_ok    = ~hold & ~clr;
    assign req_ready = arb_ok ? pick_gnt : '0;
    assign hs        = arb_ok & pick_any;

    // Grant is one-hot, so an OR of masked lanes is the selected lane.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_en_d = '0;
        if (hs && (sel_addr != '0)) begin
            wr_en_d = NREG'(addr_dec(MAX_ADDR_W'(sel_addr)));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            if (pick_idx == IW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q <= '0;
        end else if (hs) begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_en_q   <= '0;
            wr_fire_q <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_fire_q <= hs;
        end
    end

    // Payload registers keep their last write when nothing fires.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_data_q <= '0;
            wr_addr_q <= '0;
            gnt_id_q  <= '0;
        end else if (hs) begin
            wr_data_q <= sel_data;
            wr_addr_q <= sel_addr;
            gnt_id_q  <= pick_idx;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_data = wr_data_q;
    assign wr_addr = wr_addr_q;
    assign gnt_id  = gnt_id_q;
    assign wr_fire = wr_fire_q;

endmodule

// File: tb/tb_regwr_arbiter.sv
// Bench for regwr_arbiter: directed cases plus random traffic
// against a transaction-level round-robin model.
module tb_regwr_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            clr;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [31:0]     wr_en;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   wr_addr;
    logic [1:0]      gnt_id;
    logic            wr_fire;

    regwr_arbiter dut (
        .clk       (clk),
        .clr       (clr),
        .hold      (hold),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .gnt_id    (gnt_id),
        .wr_fire   (wr_fire)
    );

    always #5 clk = ~clk;

    logic [31:0] bank [32];
    always @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    int total = 0;
    int bad   = 0;

    logic        v  [N];
    logic [4:0]  a  [N];
    logic [31:0] d  [N];
    int          wt [N];

    int          pm;
    logic        ef;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [1:0]  eg;
    int          last_g;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = v[i];
            req_addr[i*AW +: AW]   = a[i];
            req_data[i*DW +: DW]   = d[i];
        end
    endtask

    task automatic step(input bit rnd);
        int g;
        logic [63:0] exp_en;
        drive();
        @(negedge clk);
        g = -1;
        if (!hold && !clr) begin
            for (int j = 0; j < N; j++) begin
                if (g < 0 && v[(pm + j) % N]) g = (pm + j) % N;
            end
        end
        chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'd0);
        exp_en = (ef && ea != 0) ? 64'(1) << ea : 64'd0;
        chk("wr_fire", 64'(wr_fire), 64'(ef));
        chk("wr_en", 64'(wr_en), exp_en);
        chk("wr_addr", 64'(wr_addr), 64'(ea));
        chk("wr_data", 64'(wr_data), 64'(ed));
        chk("gnt_id", 64'(gnt_id), 64'(eg));
        if (!hold && !clr) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && i != g) wt[i]++;
            end
        end
        last_g = g;
        if (g >= 0) begin
            ef = 1'b1;
            ea = a[g];
            ed = d[g];
            eg = 2'(g);
            pm = (g + 1) % N;
            chk("starve", 64'(wt[g] <= N - 1), 64'd1);
            wt[g] = 0;
        end else begin
            ef = 1'b0;
        end
        if (rnd) begin
            if (g >= 0) begin
                v[g] = ($urandom % 3) != 0;
                a[g] = 5'($urandom);
                d[g] = $urandom;
            end
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom % 2) == 1) begin
                    v[i]  = 1'b1;
                    a[i]  = 5'($urandom);
                    d[i]  = $urandom;
                    wt[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_fire", 64'(wr_fire), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        chk("rst_data", 64'(wr_data), 64'd0);
        chk("rst_gid", 64'(gnt_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        pm = 0;
        ef = 1'b0;
        ea = '0;
        ed = '0;
        eg = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        step(0);
        clr = 1'b0;
    endtask

    task automatic all_valid();
        for (int i = 0; i < N; i++) begin
            v[i]  = 1'b1;
            a[i]  = 5'(i + 1);
            d[i]  = $urandom;
            wt[i] = 0;
        end
    endtask

    task automatic none_valid();
        for (int i = 0; i < N; i++) v[i] = 1'b0;
    endtask

    initial begin
        int n;
        clr  = 1'b1;
        hold = 1'b0;
        none_valid();
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
        do_reset();

        all_valid();
        for (int k = 0; k < 5; k++) begin
            step(0);
            chk("order_a", 64'(last_g), 64'(k % N));
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(0);
            chk("order_b", 64'(last_g), 64'(k % N));
        end

        do_reset();
        none_valid();
        v[1] = 1'b1;
        a[1] = 5'd9;
        d[1] = 32'h1111;
        step(0);
        v[0] = 1'b1;
        a[0] = 5'd7;
        d[0] = 32'h7777;
        step(0);
        chk("rot_first", 64'(last_g), 64'd0);
        v[0] = 1'b0;
        step(0);
        chk("rot_second", 64'(last_g), 64'd1);
        none_valid();
        step(0);

        do_reset();
        none_valid();
        v[1] = 1'b1;
        a[1] = 5'd0;
        d[1] = 32'hDEADBEEF;
        step(0);
        all_valid();
        step(0);
        chk("a0_ptr", 64'(last_g), 64'd2);
        none_valid();
        step(0);
        step(0);

        do_reset();
        all_valid();
        step(0);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) step(0);
        hold = 1'b0;
        step(0);
        chk("hold_resume", 64'(last_g), 64'd1);
        none_valid();
        step(0);

        do_reset();
        none_valid();
        v[0] = 1'b1;
        a[0] = 5'd5;
        d[0] = 32'h1;
        v[1] = 1'b1;
        a[1] = 5'd5;
        d[1] = 32'h2;
        step(0);
        v[0] = 1'b0;
        step(0);
        v[1] = 1'b0;
        step(0);
        step(0);
        chk("same_addr", 64'(bank[5]), 64'h2);

        do_reset();
        all_valid();
        n = 0;
        last_g = -1;
        while (n < 8 && last_g != 3) begin
            step(0);
            n++;
        end
        chk("req3_wait", 64'(n <= N), 64'd1);

        for (int k = 0; k < 1000; k++) begin
            hold = ($urandom % 8) == 0;
            step(1);
        end
        hold = 1'b0;
        none_valid();
        step(0);
        step(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing the register-file write port.
REQ-002 Parameter ADDR_W, default 5, register address width; NREG = 2**ADDR_W registers.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 hold  input  1  high: no new grants issued (register bank busy or frozen).
REQ-007 req_valid  input  NREQ  per-requester write request.
REQ-008 req_addr  input  NREQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 req_data  input  NREQ*DATA_W  packed write data; same packing as REQ-008.
REQ-010 req_ready  output  NREQ  one-hot grant; a handshake is req_valid[i] & req_ready[i].
REQ-011 wr_en  output  NREG  one-hot per-register enable driving the register bank flop enables.
REQ-012 wr_data  output  DATA_W  data presented to all registers.
REQ-013 wr_addr  output  ADDR_W  address of the current write (debug/bypass use).
REQ-014 gnt_id  output  clog2(NREQ)  index of the requester whose write is on wr_en this cycle.
REQ-015 wr_fire  output  1  high when a registered write is being issued (includes writes to address 0).

Function
REQ-016 Grant SHALL be combinational: when hold=0, req_ready asserts for the first valid requester at or after rotating pointer ptr, modulo NREQ.
REQ-017 At most one req_ready bit SHALL be high per cycle; all SHALL be 0 when hold=1 or no req_valid is set.
REQ-018 Requesters SHALL hold valid/addr/data stable until handshake; the arbiter SHALL NOT depend on ready to drive valid.
REQ-019 On a handshake in cycle N, ptr SHALL become (granted index + 1) mod NREQ in cycle N+1; with no handshake ptr is unchanged.
REQ-020 Handshake in cycle N SHALL produce wr_fire=1, wr_addr, wr_data, gnt_id and one-hot wr_en[addr] registered in cycle N+1 (latency 1).
REQ-021 Without a handshake in cycle N, wr_en SHALL be all-zero and wr_fire=0 in N+1; wr_data, wr_addr and gnt_id SHALL hold their last values.
REQ-022 A handshake to address 0 SHALL complete normally (wr_fire=1, ptr advances) but wr_en SHALL remain all-zero (r0 hard-wired zero).
REQ-023 Back-to-back grants SHALL be sustained: one write per cycle while requests remain and hold=0.
REQ-024 Consecutive grants to the same address SHALL both issue, in grant order; the later write prevails.
REQ-025 hold rising while a write is registered SHALL NOT cancel that write; it issues in the following cycle.
REQ-026 Fairness: a continuously valid requester SHALL be granted within NREQ cycles of hold=0 cycles.

Reset
REQ-027 clr SHALL asynchronously force ptr=0, wr_en=0, wr_fire=0, wr_data=0, wr_addr=0, gnt_id=0.
REQ-028 req_ready SHALL be 0 while clr=1; the first grant SHALL occur on the first hold=0 cycle after clr deasserts.
REQ-029 clr asserted in the cycle after a handshake SHALL suppress the pending write (wr_en never asserts).

Structure
REQ-030 Shared package SHALL hold default NREQ, ADDR_W, DATA_W and a one-hot address-decode function.
REQ-031 Sub-module rr_pick SHALL implement the rotating-base priority pick (inputs: request vector, ptr; outputs: one-hot grant, index, any).
REQ-032 Output and pointer registers SHALL be built from the team's standard enable/clear flop cell behaviour (async clr, load on enable).

Verification
REQ-033 Reset: clr=1 mid-stream -> wr_en=0, ptr=0 immediately; after release, req_valid=4'b1111 -> grant order 0,1,2,3,0.
REQ-034 Rotation: ptr=2, req_valid=4'b0011 -> req_ready=4'b0001; next cycle wr_en[addr0 of req 0] and gnt_id=0, then req 1 granted.
REQ-035 Address 0: requester 1 writes addr 0, data 0xDEADBEEF -> wr_fire=1, wr_en=0, ptr advances to 2.
REQ-036 Hold: all valid, hold=1 for 3 cycles -> req_ready=0 and wr_fire=0 in the three cycles after; the write granted just before hold still issues once.
REQ-037 Same address: req 0 addr 5 data 0x1 then req 1 addr 5 data 0x2 -> wr_en[5] two consecutive cycles, final register value 0x2.
REQ-038 Fairness: requester 3 held valid with 0-2 continuously valid -> requester 3 granted within 4 cycles; repeat 1000 random cycles with no starvation beyond NREQ.
